// File: rtl/exe_operand_issue.sv
// exe_operand_issue: selects ALU operands from decoded fields, buffers them in
// a 2-entry skid buffer and issues them to execute under valid/ready.
// dec_ready_o comes from registered occupancy only, so execute back-pressure
// never reaches decode combinationally. DATA_WIDTH is intended to be 32 or 64.
module exe_operand_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int EXE_CTRL_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      dec_valid_i,
  output logic                      dec_ready_o,
  input  logic [DATA_WIDTH-1:0]     dec_rs1_i,
  input  logic [DATA_WIDTH-1:0]     dec_rs2_i,
  input  logic [DATA_WIDTH-1:0]     dec_imm_i,
  input  logic [DATA_WIDTH-1:0]     dec_pc_i,
  input  logic [1:0]                dec_op1_sel_i,
  input  logic                      dec_op2_sel_i,
  input  logic [EXE_CTRL_WIDTH-1:0] dec_ctrl_i,
  output logic                      exe_valid_o,
  input  logic                      exe_ready_i,
  output logic [DATA_WIDTH-1:0]     op1_o,
  output logic [DATA_WIDTH-1:0]     op2_o,
  output logic [EXE_CTRL_WIDTH-1:0] ctrl_o
);

  localparam int ENT_W = 2 * DATA_WIDTH + EXE_CTRL_WIDTH;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ENT_W-1:0] head_q, head_d;
  logic [ENT_W-1:0] tail_q, tail_d;
  logic [ENT_W-1:0] new_entry;
  logic             push;
  logic             pop;

  // Operand selection done once at push time; reserved op1 select reads as zero.
  function automatic logic [ENT_W-1:0] build_entry(
    input logic [DATA_WIDTH-1:0]     rs1,
    input logic [DATA_WIDTH-1:0]     rs2,
    input logic [DATA_WIDTH-1:0]     imm,
    input logic [DATA_WIDTH-1:0]     pc,
    input logic [1:0]                op1_sel,
    input logic                      op2_sel,
    input logic [EXE_CTRL_WIDTH-1:0] ctrl
  );
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    case (op1_sel)
      2'd0:    op1 = rs1;
      2'd1:    op1 = pc;
      default: op1 = '0;
    endcase
    op2 = op2_sel ? imm : rs2;
    return {op1, op2, ctrl};
  endfunction

  assign new_entry = build_entry(dec_rs1_i, dec_rs2_i, dec_imm_i, dec_pc_i,
                                 dec_op1_sel_i, dec_op2_sel_i, dec_ctrl_i);

  // Handshakes; a zero ctrl beat is accepted but never stored (bubble).
  assign dec_ready_o = (state_q != S_FULL) & ~rst_i;
  assign push        = dec_valid_i & dec_ready_o & ~flush_i & (dec_ctrl_i != '0);
  assign pop         = (state_q != S_EMPTY) & exe_ready_i & ~flush_i;

  // Occupancy register; reset outranks flush, which is handled in next-state logic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next-state: flush empties the buffer regardless of push/pop.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (push) state_d = S_ONE;
        S_ONE: begin
          if (push && !pop)      state_d = S_FULL;
          else if (pop && !push) state_d = S_EMPTY;
        end
        S_FULL:  if (pop) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Entry storage carries no reset: outputs are masked to zero while empty.
  always_ff @(posedge clk_i) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  // Entry movement: new data lands in head when it would be next to issue,
  // otherwise in tail; a pop from FULL promotes tail to head.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      S_EMPTY: if (push) head_d = new_entry;
      S_ONE: begin
        if (push && pop) head_d = new_entry;
        else if (push)   tail_d = new_entry;
      end
      S_FULL:  if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  // Issue outputs: head entry when occupied, all zero when empty.
  always_comb begin
    exe_valid_o = (state_q != S_EMPTY);
    op1_o       = '0;
    op2_o       = '0;
    ctrl_o      = '0;
    if (exe_valid_o) begin
      {op1_o, op2_o, ctrl_o} = head_q;
    end
  end

endmodule

// File: tb/tb_exe_operand_issue.sv
// Testbench for exe_operand_issue: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a queue model.
module tb_exe_operand_issue;

  localparam int DW = 32;
  localparam int CW = 5;
  localparam logic [CW-1:0] EXE_ADD = 5'h01;
  localparam logic [CW-1:0] EXE_SUB = 5'h02;

  logic          clk = 1'b0;
  logic          rst, flush, dec_valid, dec_ready, dec_op2_sel;
  logic [DW-1:0] rs1, rs2, imm, pc;
  logic [1:0]    dec_op1_sel;
  logic [CW-1:0] dec_ctrl;
  logic          exe_valid, exe_ready;
  logic [DW-1:0] op1, op2;
  logic [CW-1:0] ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [CW-1:0] ctrl;
  } ent_t;

  ent_t mq[$];

  exe_operand_issue #(.DATA_WIDTH(DW), .EXE_CTRL_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
    .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_imm_i(imm), .dec_pc_i(pc),
    .dec_op1_sel_i(dec_op1_sel), .dec_op2_sel_i(dec_op2_sel), .dec_ctrl_i(dec_ctrl),
    .exe_valid_o(exe_valid), .exe_ready_i(exe_ready),
    .op1_o(op1), .op2_o(op2), .ctrl_o(ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of at most two selected-operand records.
  always @(posedge clk) begin
    bit   pop_m, push_m;
    ent_t e;
    if (rst || flush) begin
      mq.delete();
    end else begin
      pop_m  = (mq.size() > 0) && exe_ready;
      push_m = dec_valid && (mq.size() < 2) && (dec_ctrl != 0);
      e.op1  = (dec_op1_sel == 2'd0) ? rs1 : (dec_op1_sel == 2'd1) ? pc : '0;
      e.op2  = dec_op2_sel ? imm : rs2;
      e.ctrl = dec_ctrl;
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back(e);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", exe_valid, mq.size() != 0);
      chk("m_ready", dec_ready, (mq.size() < 2) && !rst);
      chk("m_op1",  op1,  mq.size() != 0 ? mq[0].op1  : '0);
      chk("m_op2",  op2,  mq.size() != 0 ? mq[0].op2  : '0);
      chk("m_ctrl", ctrl, mq.size() != 0 ? mq[0].ctrl : '0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] im, input logic [DW-1:0] p,
                       input logic [1:0] s1, input logic s2, input logic [CW-1:0] c);
    dec_valid = v; rs1 = a; rs2 = b; imm = im; pc = p;
    dec_op1_sel = s1; dec_op2_sel = s2; dec_ctrl = c;
  endtask

  task automatic push_rs(input logic [DW-1:0] a, input logic [CW-1:0] c);
    drive(1'b1, a, a + 32'd1, 32'h0, 32'h0, 2'd0, 1'b0, c);
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, 2'd0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; exe_ready = 1'b1;
    idle();
    step();
    chk_en = 1'b1;
    step();
    // Reset state
    chk("rst_valid", exe_valid, 0);
    chk("rst_op1", op1, 0);
    chk("rst_ready_held", dec_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_ready_rel", dec_ready, 1);

    // 1: single ADD
    drive(1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 2'd0, 1'b0, EXE_ADD);
    step();
    chk("add_valid", exe_valid, 1);
    chk("add_op1", op1, 5);
    chk("add_op2", op2, 7);
    chk("add_ctrl", ctrl, EXE_ADD);
    idle();
    step();
    chk("add_drain_valid", exe_valid, 0);
    chk("add_drain_op1", op1, 0);
    chk("add_drain_ctrl", ctrl, 0);

    // 2: operand selection
    drive(1'b1, 32'h55, 32'h9, 32'hFFFF_FFFC, 32'h100, 2'd1, 1'b1, EXE_ADD);
    step();
    chk("sel_pc", op1, 32'h100);
    chk("sel_imm", op2, 32'hFFFF_FFFC);
    drive(1'b1, 32'h55, 32'h9, 32'hFFFF_FFFC, 32'h100, 2'd2, 1'b0, EXE_ADD);
    step();
    chk("sel_zero2", op1, 0);
    chk("sel_rs2", op2, 32'h9);
    drive(1'b1, 32'h55, 32'h9, 32'hFFFF_FFFC, 32'h100, 2'd3, 1'b0, EXE_SUB);
    step();
    chk("sel_zero3", op1, 0);
    chk("sel_ctrl", ctrl, EXE_SUB);
    idle();
    step();

    // 3: back-pressure with A, B, C
    exe_ready = 1'b0;
    push_rs(32'hA, EXE_ADD); step();
    push_rs(32'hB, EXE_ADD); step();
    chk("bp_ready_full", dec_ready, 0);
    chk("bp_hold_a", op1, 32'hA);
    push_rs(32'hC, EXE_ADD); step();
    chk("bp_hold_a2", op1, 32'hA);
    chk("bp_ready_full2", dec_ready, 0);
    exe_ready = 1'b1;
    step();
    chk("bp_b", op1, 32'hB);
    chk("bp_ready_one", dec_ready, 1);
    step();
    chk("bp_c", op1, 32'hC);
    idle();
    step();
    chk("bp_empty", exe_valid, 0);

    // 4: streaming 16 entries
    for (int i = 0; i < 16; i++) begin
      chk("stream_ready", dec_ready, 1);
      push_rs(32'd100 + 32'(i), EXE_ADD);
      step();
      chk("stream_valid", exe_valid, 1);
      chk("stream_op1", op1, 32'd100 + 32'(i));
    end
    idle();
    step();

    // 5: bubble between two ADDs
    exe_ready = 1'b0;
    push_rs(32'h11, EXE_ADD); step();
    push_rs(32'h77, 5'h0);    step();
    chk("bub_ready", dec_ready, 1);
    push_rs(32'h22, EXE_ADD); step();
    chk("bub_head1", op1, 32'h11);
    exe_ready = 1'b1;
    idle();
    step();
    chk("bub_head2", op1, 32'h22);
    step();
    chk("bub_empty", exe_valid, 0);

    // 6: flush in FULL with a same-cycle beat, then reset mid-stream
    exe_ready = 1'b0;
    push_rs(32'h31, EXE_ADD); step();
    push_rs(32'h32, EXE_ADD); step();
    flush = 1'b1;
    push_rs(32'h33, EXE_ADD); step();
    flush = 1'b0;
    idle();
    chk("fl_valid", exe_valid, 0);
    chk("fl_ready", dec_ready, 1);
    step();
    chk("fl_dropped", exe_valid, 0);
    push_rs(32'h41, EXE_ADD); step();
    push_rs(32'h42, EXE_ADD); step();
    rst = 1'b1;
    idle();
    step();
    chk("rs_valid", exe_valid, 0);
    chk("rs_op1", op1, 0);
    chk("rs_ready", dec_ready, 0);
    rst = 1'b0;
    #1;
    chk("rs_ready_rel", dec_ready, 1);
    exe_ready = 1'b1;
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      exe_ready   = ($urandom_range(0, 2) != 0);
      dec_valid   = ($urandom_range(0, 3) != 0);
      rs1         = $urandom;
      rs2         = $urandom;
      imm         = $urandom;
      pc          = $urandom;
      dec_op1_sel = 2'($urandom_range(0, 3));
      dec_op2_sel = 1'($urandom_range(0, 1));
      dec_ctrl    = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom_range(1, 31));
      step();
    end
    rst = 1'b0; flush = 1'b0;
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
